// File: rtl/fetch_pc_unit.sv
// IF-stage program counter with ID/EXE PC tracking, misprediction redirect/flush
// and saturating branch and misprediction statistics counters.
module fetch_pc_unit #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = 10'h000,
    parameter int              CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              stall,
    input  logic              if_prediction,
    input  logic [PC_W-1:0]   if_PBT,
    input  logic [1:0]        exe_correction,
    input  logic [PC_W-1:0]   exe_PBT,
    input  logic [PC_W-1:0]   exe_CNI,
    input  logic              exe_is_branch,
    output logic [PC_W-1:0]   if_PC,
    output logic [PC_W-1:0]   id_PC,
    output logic              id_valid,
    output logic [PC_W-1:0]   exe_PC,
    output logic              exe_valid,
    output logic              flush,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mispred_count
);

    logic            corr;
    logic            br_seen;
    logic [PC_W-1:0] next_pc;

    assign corr    = exe_valid & exe_correction[1];
    assign flush   = corr;
    assign br_seen = exe_valid & exe_is_branch;

    // A qualifying correction outranks the stall so a redirect can never be dropped.
    always_comb begin
        next_pc = if_PC + 1'b1;
        if (corr)
            next_pc = exe_correction[0] ? exe_PBT : exe_CNI;
        else if (stall)
            next_pc = if_PC;
        else if (if_prediction)
            next_pc = if_PBT;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            if_PC     <= RESET_PC;
            id_PC     <= '0;
            id_valid  <= 1'b0;
            exe_PC    <= '0;
            exe_valid <= 1'b0;
        end else begin
            if_PC <= next_pc;
            if (corr) begin
                id_PC     <= if_PC;
                id_valid  <= 1'b0;
                exe_PC    <= id_PC;
                exe_valid <= 1'b0;
            end else if (stall) begin
                exe_PC    <= id_PC;
                exe_valid <= 1'b0;
            end else begin
                id_PC     <= if_PC;
                id_valid  <= 1'b1;
                exe_PC    <= id_PC;
                exe_valid <= id_valid;
            end
        end
    end

    // Statistics counters stick at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (rst) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (br_seen && (br_count != {CNT_W{1'b1}}))
                br_count <= br_count + 1'b1;
            if (corr && (mispred_count != {CNT_W{1'b1}}))
                mispred_count <= mispred_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table, corner sequences
// and randomized traffic against a behavioural model of the fetch front end.
module tb_fetch_pc_unit;

    localparam int              PC_W   = 10;
    localparam int              CNT_W  = 16;
    localparam int              SCNT_W = 2;
    localparam logic [PC_W-1:0] RST_PC = 10'h010;

    logic              CLK = 1'b0;
    logic              rst;
    logic              stall;
    logic              if_prediction;
    logic [PC_W-1:0]   if_PBT;
    logic [1:0]        exe_correction;
    logic [PC_W-1:0]   exe_PBT;
    logic [PC_W-1:0]   exe_CNI;
    logic              exe_is_branch;
    logic [PC_W-1:0]   if_PC, id_PC, exe_PC;
    logic              id_valid, exe_valid, flush;
    logic [CNT_W-1:0]  br_count, mispred_count;
    logic [PC_W-1:0]   s_if_PC, s_id_PC, s_exe_PC;
    logic              s_id_valid, s_exe_valid, s_flush;
    logic [SCNT_W-1:0] s_br_count, s_mispred_count;

    fetch_pc_unit #(.PC_W(PC_W), .RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .rst(rst), .stall(stall), .if_prediction(if_prediction), .if_PBT(if_PBT),
        .exe_correction(exe_correction), .exe_PBT(exe_PBT), .exe_CNI(exe_CNI),
        .exe_is_branch(exe_is_branch), .if_PC(if_PC), .id_PC(id_PC), .id_valid(id_valid),
        .exe_PC(exe_PC), .exe_valid(exe_valid), .flush(flush), .br_count(br_count),
        .mispred_count(mispred_count)
    );

    // Narrow-counter copy so saturation is reachable in a few cycles.
    fetch_pc_unit #(.PC_W(PC_W), .RESET_PC(RST_PC), .CNT_W(SCNT_W)) dut_small (
        .CLK(CLK), .rst(rst), .stall(stall), .if_prediction(if_prediction), .if_PBT(if_PBT),
        .exe_correction(exe_correction), .exe_PBT(exe_PBT), .exe_CNI(exe_CNI),
        .exe_is_branch(exe_is_branch), .if_PC(s_if_PC), .id_PC(s_id_PC), .id_valid(s_id_valid),
        .exe_PC(s_exe_PC), .exe_valid(s_exe_valid), .flush(s_flush), .br_count(s_br_count),
        .mispred_count(s_mispred_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    int m_if, m_id, m_idv, m_exe, m_exev, m_br, m_mis;

    typedef struct {
        logic            stall;
        logic            pred;
        logic [PC_W-1:0] pbt;
        logic [1:0]      corr;
        logic [PC_W-1:0] epbt;
        logic [PC_W-1:0] ecni;
        logic            br;
        logic            exp_flush;
        logic [PC_W-1:0] exp_if;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Model of one clock edge, derived directly from the redirect/stall/predict priorities.
    task automatic modelStep();
        int do_corr = (m_exev != 0 && exe_correction[1]) ? 1 : 0;
        int n_if;
        if (rst) begin
            m_if = RST_PC; m_id = 0; m_idv = 0; m_exe = 0; m_exev = 0; m_br = 0; m_mis = 0;
            return;
        end
        if (m_exev != 0 && exe_is_branch) m_br++;
        if (do_corr != 0) m_mis++;
        if (do_corr != 0)     n_if = exe_correction[0] ? int'(exe_PBT) : int'(exe_CNI);
        else if (stall)       n_if = m_if;
        else if (if_prediction) n_if = int'(if_PBT);
        else                  n_if = (m_if + 1) % (1 << PC_W);
        if (do_corr != 0) begin
            m_exe = m_id; m_id = m_if; m_idv = 0; m_exev = 0;
        end else if (stall) begin
            m_exe = m_id; m_exev = 0;
        end else begin
            m_exe = m_id; m_exev = m_idv; m_id = m_if; m_idv = 1;
        end
        m_if = n_if;
    endtask

    task automatic checkOutput();
        chk("if_PC", int'(if_PC), m_if);
        chk("id_PC", int'(id_PC), m_id);
        chk("id_valid", int'(id_valid), m_idv);
        chk("exe_PC", int'(exe_PC), m_exe);
        chk("exe_valid", int'(exe_valid), m_exev);
        chk("br_count", int'(br_count), sat(m_br, CNT_W));
        chk("mispred_count", int'(mispred_count), sat(m_mis, CNT_W));
        chk("small_br_count", int'(s_br_count), sat(m_br, SCNT_W));
        chk("small_mispred_count", int'(s_mispred_count), sat(m_mis, SCNT_W));
    endtask

    task automatic applyStimulus();
        #1;
        chk("flush", int'(flush), (m_exev != 0 && exe_correction[1]) ? 1 : 0);
        @(posedge CLK);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic idleInputs();
        rst = 1'b0; stall = 1'b0; if_prediction = 1'b0; if_PBT = '0;
        exe_correction = 2'b00; exe_PBT = '0; exe_CNI = '0; exe_is_branch = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 10'h000, 2'b00, 10'h000, 10'h000, 1'b0, 1'b0, 10'h011};
        vecs[1]  = '{1'b0, 1'b0, 10'h000, 2'b00, 10'h000, 10'h000, 1'b0, 1'b0, 10'h012};
        vecs[2]  = '{1'b0, 1'b0, 10'h000, 2'b00, 10'h000, 10'h000, 1'b1, 1'b0, 10'h013};
        vecs[3]  = '{1'b0, 1'b1, 10'h020, 2'b00, 10'h000, 10'h000, 1'b0, 1'b0, 10'h020};
        vecs[4]  = '{1'b0, 1'b1, 10'h100, 2'b00, 10'h000, 10'h000, 1'b1, 1'b0, 10'h100};
        vecs[5]  = '{1'b1, 1'b1, 10'h222, 2'b11, 10'h155, 10'h0AA, 1'b1, 1'b1, 10'h155};
        vecs[6]  = '{1'b0, 1'b0, 10'h000, 2'b00, 10'h000, 10'h000, 1'b1, 1'b0, 10'h156};
        vecs[7]  = '{1'b0, 1'b0, 10'h000, 2'b10, 10'h2BB, 10'h0A4, 1'b0, 1'b0, 10'h157};
        vecs[8]  = '{1'b0, 1'b0, 10'h000, 2'b10, 10'h2BB, 10'h0A4, 1'b0, 1'b1, 10'h0A4};
        vecs[9]  = '{1'b0, 1'b1, 10'h040, 2'b00, 10'h000, 10'h000, 1'b0, 1'b0, 10'h040};
        vecs[10] = '{1'b1, 1'b1, 10'h3AA, 2'b00, 10'h000, 10'h000, 1'b0, 1'b0, 10'h040};
        vecs[11] = '{1'b1, 1'b1, 10'h3AA, 2'b00, 10'h000, 10'h000, 1'b0, 1'b0, 10'h040};
        vecs[12] = '{1'b1, 1'b1, 10'h3AA, 2'b00, 10'h000, 10'h000, 1'b0, 1'b0, 10'h040};
        vecs[13] = '{1'b0, 1'b0, 10'h000, 2'b00, 10'h000, 10'h000, 1'b0, 1'b0, 10'h041};
        vecs[14] = '{1'b0, 1'b1, 10'h3FF, 2'b00, 10'h000, 10'h000, 1'b1, 1'b0, 10'h3FF};
        vecs[15] = '{1'b0, 1'b0, 10'h000, 2'b00, 10'h000, 10'h000, 1'b1, 1'b0, 10'h000};
        vecs[16] = '{1'b0, 1'b0, 10'h000, 2'b00, 10'h000, 10'h000, 1'b0, 1'b0, 10'h001};

        m_if = 0; m_id = 0; m_idv = 0; m_exe = 0; m_exev = 0; m_br = 0; m_mis = 0;
        idleInputs();
        rst = 1'b1;
        @(posedge CLK);
        modelStep();
        #1;
        applyStimulus();
        chk("reset_if_PC", int'(if_PC), 32'h010);
        chk("reset_flush", int'(flush), 0);

        rst = 1'b0;
        foreach (vecs[i]) begin
            stall = vecs[i].stall; if_prediction = vecs[i].pred; if_PBT = vecs[i].pbt;
            exe_correction = vecs[i].corr; exe_PBT = vecs[i].epbt; exe_CNI = vecs[i].ecni;
            exe_is_branch = vecs[i].br;
            #1;
            chk($sformatf("vec%0d_flush", i), int'(flush), int'(vecs[i].exp_flush));
            applyStimulus();
            chk($sformatf("vec%0d_if_PC", i), int'(if_PC), int'(vecs[i].exp_if));
        end

        // Repeated corrections drive the narrow counter into saturation.
        for (int k = 0; k < 4; k++) begin
            idleInputs();
            exe_correction = 2'b11; exe_PBT = 10'h300 + 10'(k); exe_is_branch = 1'b1;
            applyStimulus();
            chk("redirect_target", int'(if_PC), 32'h300 + k);
            idleInputs();
            applyStimulus();
            applyStimulus();
        end
        chk("small_mispred_saturated", int'(s_mispred_count), 3);

        // Reset wins over a simultaneous correction, stall and prediction.
        idleInputs();
        rst = 1'b1; stall = 1'b1; if_prediction = 1'b1; if_PBT = 10'h155;
        exe_correction = 2'b11; exe_PBT = 10'h2AA; exe_is_branch = 1'b1;
        applyStimulus();
        chk("midrst_if_PC", int'(if_PC), 32'h010);
        chk("midrst_mispred", int'(mispred_count), 0);
        chk("midrst_br", int'(br_count), 0);

        idleInputs();
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(0, 63) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            if_prediction  = $urandom_range(0, 1) == 1;
            if_PBT         = PC_W'($urandom);
            exe_correction = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            exe_PBT        = PC_W'($urandom);
            exe_CNI        = PC_W'($urandom);
            exe_is_branch  = $urandom_range(0, 1) == 1;
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
